prog_blinker: RTL and testbench

- Programmable-rate blinker feeding the light mux's BLINK inputs; two instances, one driven by the slow_left/slow_right pair and one by fast_left/fast_right.
- Holds a one-hot half-period (in ticks) that is doubled by a shift-left pulse and halved by a shift-right pulse.
- Toggles its blink output every half-period of enable ticks, paced by an external beat/tick strobe.

---
 rtl/prog_blinker_pkg.sv | 26 ++
 rtl/prog_blinker_blink_rate_reg.sv | 54 +++++
 rtl/prog_blinker.sv | 66 ++++++
 tb/tb_prog_blinker.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/prog_blinker_pkg.sv
// Shared definitions for the programmable-rate blinker.
//   BLINK_RATE_WIDTH : width of the one-hot rate register and the tick counter
//   BLINK_RATE_RESET : one-hot half-period (in ticks) loaded on reset
//   shift_req_e      : decoded shift request from the slower/faster inputs
//   decode_shift()   : maps the two shift inputs onto shift_req_e
package prog_blinker_pkg;

    localparam int BLINK_RATE_WIDTH = 4;
    localparam logic [BLINK_RATE_WIDTH-1:0] BLINK_RATE_RESET = 4'b0100;

    typedef enum logic [1:0] {
        SHIFT_HOLD = 2'b00,
        SHIFT_UP   = 2'b01,
        SHIFT_DOWN = 2'b10
    } shift_req_e;

    // Both or neither asserted means no change.
    function automatic shift_req_e decode_shift(input logic i_left, input logic i_right);
        case ({i_left, i_right})
            2'b10:   return SHIFT_UP;
            2'b01:   return SHIFT_DOWN;
            default: return SHIFT_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/prog_blinker_blink_rate_reg.sv
// Saturating one-hot half-period register.
//   clk            : system clock
//   reset          : synchronous, active-high
//   i_shift_left   : double the half-period (saturates at the MSB)
//   i_shift_right  : halve the half-period (saturates at the LSB)
//   o_rate         : current one-hot half-period
//   o_rate_changed : high in the cycle a shift is actually accepted; the new
//                    rate appears on o_rate after the following edge
module blink_rate_reg
    import prog_blinker_pkg::*;
#(
    parameter int                 WIDTH      = BLINK_RATE_WIDTH,
    parameter logic [WIDTH-1:0]   RESET_RATE = BLINK_RATE_RESET
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_shift_left,
    input  logic             i_shift_right,
    output logic [WIDTH-1:0] o_rate,
    output logic             o_rate_changed
);

    logic [WIDTH-1:0] r_rate;
    shift_req_e       w_req;
    logic             w_accept;

    assign w_req = decode_shift(i_shift_left, i_shift_right);

    // A shift into the saturated end is a no-op and must not be reported as
    // a change, otherwise the counter would be cleared for nothing.
    always_comb begin
        w_accept = 1'b0;
        case (w_req)
            SHIFT_UP:   w_accept = ~r_rate[WIDTH-1];
            SHIFT_DOWN: w_accept = ~r_rate[0];
            default:    w_accept = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rate <= RESET_RATE;
        end else if (w_accept) begin
            if (w_req == SHIFT_UP)
                r_rate <= r_rate << 1;
            else
                r_rate <= r_rate >> 1;
        end
    end

    assign o_rate         = r_rate;
    assign o_rate_changed = w_accept;

endmodule

// File: rtl/prog_blinker.sv
// Programmable-rate blinker: toggles blink every 'rate' enable ticks, where
// rate is a one-hot half-period adjusted by slower/faster pulses.
//   clk         : system clock
//   reset       : synchronous, active-high; wins over every other input
//   tick        : single-cycle enable strobe from the beat generator
//   shift_left  : slower request (doubles the half-period)
//   shift_right : faster request (halves the half-period)
//   blink       : registered square wave, period 2*rate ticks
//   rate        : current one-hot half-period
module prog_blinker
    import prog_blinker_pkg::*;
#(
    parameter int                 WIDTH      = BLINK_RATE_WIDTH,
    parameter logic [WIDTH-1:0]   RESET_RATE = BLINK_RATE_RESET
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             shift_left,
    input  logic             shift_right,
    output logic             blink,
    output logic [WIDTH-1:0] rate
);

    logic [WIDTH-1:0] w_rate;
    logic             w_rate_changed;
    logic [WIDTH-1:0] w_rate_last;
    logic [WIDTH-1:0] r_cnt;
    logic             r_blink;

    blink_rate_reg #(
        .WIDTH      (WIDTH),
        .RESET_RATE (RESET_RATE)
    ) u_rate_reg (
        .clk            (clk),
        .reset          (reset),
        .i_shift_left   (shift_left),
        .i_shift_right  (shift_right),
        .o_rate         (w_rate),
        .o_rate_changed (w_rate_changed)
    );

    // rate is at most 2^(WIDTH-1), so cnt reaches rate-1 before it could wrap.
    assign w_rate_last = w_rate - {{(WIDTH-1){1'b0}}, 1'b1};

    // An accepted shift restarts the half-period; a coincident tick is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_blink <= 1'b0;
        end else if (w_rate_changed) begin
            r_cnt   <= '0;
        end else if (tick) begin
            if (r_cnt == w_rate_last) begin
                r_cnt   <= '0;
                r_blink <= ~r_blink;
            end else begin
                r_cnt   <= r_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign blink = r_blink;
    assign rate  = w_rate;

endmodule

// File: tb/tb_prog_blinker.sv
module tb_prog_blinker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       shift_left = 1'b0;
    logic       shift_right = 1'b0;
    logic       blink;
    logic [3:0] rate;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: half-period as a plain integer, ticks counted since
    // the last restart of the half-period.
    int   m_half  = 4;
    int   m_ticks = 0;
    logic m_blink = 1'b0;

    typedef struct {
        logic       rst;
        logic       tk;
        logic       sl;
        logic       sr;
        logic       exp_blink;
        logic [3:0] exp_rate;
    } vec_t;

    vec_t vecs[$];

    prog_blinker dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .shift_left  (shift_left),
        .shift_right (shift_right),
        .blink       (blink),
        .rate        (rate)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic tk, input logic sl,
                                input logic sr, input logic eb, input logic [3:0] er);
        vec_t v;
        v.rst = rst; v.tk = tk; v.sl = sl; v.sr = sr;
        v.exp_blink = eb; v.exp_rate = er;
        return v;
    endfunction

    // Drive one cycle's inputs, take the rising edge, advance the model,
    // and leave time #1 past the edge for sampling.
    task automatic apply(input logic rst, input logic tk, input logic sl, input logic sr);
        bit changed;
        @(negedge clk);
        reset = rst; tick = tk; shift_left = sl; shift_right = sr;
        @(posedge clk);
        if (rst) begin
            m_half = 4; m_ticks = 0; m_blink = 1'b0;
        end else begin
            changed = 1'b0;
            if (sl && !sr && m_half < 8) begin
                m_half = m_half * 2; changed = 1'b1;
            end else if (sr && !sl && m_half > 1) begin
                m_half = m_half / 2; changed = 1'b1;
            end
            if (changed) begin
                m_ticks = 0;
            end else if (tk) begin
                m_ticks = m_ticks + 1;
                if (m_ticks == m_half) begin
                    m_ticks = 0;
                    m_blink = ~m_blink;
                end
            end
        end
        #1;
    endtask

    task automatic check(input string name, input logic eb, input logic [3:0] er);
        n_cmp++;
        if (blink !== eb || rate !== er) begin
            n_fail++;
            $display("FAIL %s: got blink=%0b rate=%b, required blink=%0b rate=%b",
                     name, blink, rate, eb, er);
        end
    endtask

    task automatic step_chk(input string name, input logic rst, input logic tk,
                            input logic sl, input logic sr, input logic eb,
                            input logic [3:0] er);
        apply(rst, tk, sl, sr);
        check(name, eb, er);
    endtask

    initial begin
        // Reset, then continuous ticks at rate 4: rise on tick 4, fall on tick 8.
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'b0100));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0, 1, 0, 0, (i >= 4 && i < 8), 4'b0100));
        // shift_right held three cycles: 0010, 0001, saturated 0001; then toggle every tick.
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'b0100));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'b0010));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'b0001));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'b0001));
        for (int i = 1; i <= 4; i++)
            vecs.push_back(mk(0, 1, 0, 0, i[0], 4'b0001));
        // shift_left to 1000; first toggle after 8 ticks; saturated shift keeps count.
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'b0100));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'b1000));
        for (int i = 1; i <= 11; i++)
            vecs.push_back(mk(0, 1, 0, 0, (i >= 8), 4'b1000));
        // Saturated shift_left with tick: counts as tick 12 of the half-period.
        vecs.push_back(mk(0, 1, 1, 0, 1, 4'b1000));
        for (int i = 13; i <= 16; i++)
            vecs.push_back(mk(0, 1, 0, 0, (i < 16), 4'b1000));

        foreach (vecs[k]) begin
            apply(vecs[k].rst, vecs[k].tk, vecs[k].sl, vecs[k].sr);
            check($sformatf("vec%0d", k), vecs[k].exp_blink, vecs[k].exp_rate);
        end

        // Both shifts with tick on cnt=3 at rate 4: no rate change, toggle, cnt cleared.
        step_chk("both_rst", 1, 0, 0, 0, 0, 4'b0100);
        repeat (3) step_chk("both_pre", 0, 1, 0, 0, 0, 4'b0100);
        step_chk("both_tog", 0, 1, 1, 1, 1, 4'b0100);
        repeat (3) step_chk("both_hold", 0, 1, 0, 0, 1, 4'b0100);
        step_chk("both_next", 0, 1, 0, 0, 0, 4'b0100);

        // Accepted shift_right on the tick that would toggle: tick lost, 2 more ticks.
        step_chk("coin_rst", 1, 0, 0, 0, 0, 4'b0100);
        repeat (3) step_chk("coin_pre", 0, 1, 0, 0, 0, 4'b0100);
        step_chk("coin_shift", 0, 1, 0, 1, 0, 4'b0010);
        step_chk("coin_t1", 0, 1, 0, 0, 0, 4'b0010);
        step_chk("coin_t2", 0, 1, 0, 0, 1, 4'b0010);

        // Reset mid-count with blink=1 and rate 1000; idle, then full RESET_RATE ticks.
        step_chk("mid_rst", 1, 0, 0, 0, 0, 4'b0100);
        for (int i = 1; i <= 6; i++)
            step_chk("mid_tick", 0, 1, 0, 0, (i >= 4), 4'b0100);
        step_chk("mid_sl", 0, 0, 1, 0, 1, 4'b1000);
        step_chk("mid_reset", 1, 1, 1, 0, 0, 4'b0100);
        repeat (10) step_chk("mid_idle", 0, 0, 0, 0, 0, 4'b0100);
        for (int i = 1; i <= 4; i++)
            step_chk("mid_after", 0, 1, 0, 0, (i == 4), 4'b0100);

        // Randomized traffic against the reference model.
        apply(1, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic rst_r, tk_r, sl_r, sr_r;
            rst_r = ($urandom_range(0, 99) == 0);
            tk_r  = ($urandom_range(0, 1) == 1);
            sl_r  = ($urandom_range(0, 9) == 0);
            sr_r  = ($urandom_range(0, 9) == 0);
            apply(rst_r, tk_r, sl_r, sr_r);
            check($sformatf("rand%0d", n), m_blink, 4'(m_half));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
